// File: rtl/poly_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : poly_pkg                                                      |
// | Purpose  : Shared constants, op decode type and mod-Q negation helper    |
// |            for the polynomial multiplier datapath.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package poly_pkg;

  localparam int N_DEFAULT = 8;
  localparam int W_DEFAULT = 8;
  localparam int Q_DEFAULT = 256;
  localparam int CNT_W     = $clog2(N_DEFAULT);

  // Decoded per-cycle action of a CSR bank.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_ROT  = 2'd2
  } csr_op_e;

  // Additive inverse mod q for a reduced coefficient (c < q).
  // Zero maps to zero rather than to q.
  function automatic logic [31:0] neg_mod(input logic [31:0] c, input logic [31:0] q);
    return (c == 32'd0) ? 32'd0 : (q - c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_coef_neg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : poly_coef_neg                                                 |
// | Purpose  : Combinational W-bit negation modulo Q.                        |
// | Ports    : i_coef     [W-1:0] reduced coefficient in                     |
// |            o_coef_neg [W-1:0] (Q - i_coef) mod Q                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module poly_coef_neg
  import poly_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int Q = Q_DEFAULT
) (
  input  logic [W-1:0] i_coef,
  output logic [W-1:0] o_coef_neg
);

  // With i_coef < Q <= 2^W the result always fits in W bits, so the
  // truncation never drops significant bits.
  assign o_coef_neg = W'(neg_mod(32'(i_coef), 32'(Q)));

endmodule
`default_nettype wire

// File: rtl/poly_csr_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : poly_csr_bank                                                 |
// | Purpose  : Circular shift register bank holding one polynomial's N       |
// |            coefficients; rotates toward index 0 on en, optionally        |
// |            negating the wrapped coefficient (ring Z_Q[x]/(x^N+1)).       |
// | Ports    : clk      rising-edge clock                                    |
// |            reset    asynchronous active-low reset                        |
// |            load     parallel load strobe (wins over en)                  |
// |            en       rotate-by-one strobe                                 |
// |            din      N*W packed coefficients, coeff i at [i*W +: W]       |
// |            head     coefficient at position 0                            |
// |            dout     full contents, same packing as din                   |
// |            rot_cnt  rotations since last load, mod N                     |
// |            wrap     one-cycle pulse after rot_cnt returns to 0           |
// |            phase    1 = contents negated w.r.t. loaded polynomial        |
// |            valid    bank holds loaded data                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module poly_csr_bank
  import poly_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int W          = W_DEFAULT,
  parameter int Q          = Q_DEFAULT,
  parameter int NEGACYCLIC = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   en,
  input  logic [N*W-1:0]         din,
  output logic [W-1:0]           head,
  output logic [N*W-1:0]         dout,
  output logic [$clog2(N)-1:0]   rot_cnt,
  output logic                   wrap,
  output logic                   phase,
  output logic                   valid
);

  localparam int                 c_cnt_w    = $clog2(N);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

  logic [N*W-1:0]     r_dout;
  logic [c_cnt_w-1:0] r_rot_cnt;
  logic               r_wrap;
  logic               r_phase;
  logic               r_valid;

  csr_op_e            w_op;
  logic [W-1:0]       w_tail;
  logic               w_phase_flip;

  // Rotation is only meaningful once data has been loaded.
  always_comb begin
    w_op = OP_HOLD;
    if (load) begin
      w_op = OP_LOAD;
    end else if (en && r_valid) begin
      w_op = OP_ROT;
    end
  end

  // Value re-entering at index N-1: coefficient 0 moves past x^N, which is
  // -1 in the negacyclic ring.
  generate
    if (NEGACYCLIC != 0) begin : g_neg
      poly_coef_neg #(
        .W (W),
        .Q (Q)
      ) u_coef_neg (
        .i_coef     (r_dout[W-1:0]),
        .o_coef_neg (w_tail)
      );
      assign w_phase_flip = ~r_phase;
    end else begin : g_cyc
      assign w_tail       = r_dout[W-1:0];
      assign w_phase_flip = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout    <= '0;
      r_rot_cnt <= '0;
      r_wrap    <= 1'b0;
      r_phase   <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      unique case (w_op)
        OP_LOAD: begin
          r_dout    <= din;
          r_rot_cnt <= '0;
          r_phase   <= 1'b0;
          r_valid   <= 1'b1;
        end
        OP_ROT: begin
          r_dout    <= {w_tail, r_dout[N*W-1:W]};
          // N is a power of two, so the natural overflow is the mod-N wrap.
          r_rot_cnt <= r_rot_cnt + c_cnt_w'(1);
          if (r_rot_cnt == c_cnt_last) begin
            r_wrap  <= 1'b1;
            r_phase <= w_phase_flip;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head    = r_dout[W-1:0];
  assign dout    = r_dout;
  assign rot_cnt = r_rot_cnt;
  assign wrap    = r_wrap;
  assign phase   = r_phase;
  assign valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_poly_csr_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_poly_csr_bank                                              |
// | Purpose  : Self-checking bench for poly_csr_bank; one negacyclic and one |
// |            cyclic instance share the same stimulus.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_poly_csr_bank;
  import poly_pkg::*;

  localparam int N = 8;
  localparam int W = 8;
  localparam int Q = 256;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic           load  = 1'b0;
  logic           en    = 1'b0;
  logic [N*W-1:0] din   = '0;

  logic [W-1:0]     head_n, head_c;
  logic [N*W-1:0]   dout_n, dout_c;
  logic [CNT_W-1:0] rot_n, rot_c;
  logic             wrap_n, wrap_c, phase_n, phase_c, valid_n, valid_c;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b1;

  poly_csr_bank #(.N(N), .W(W), .Q(Q), .NEGACYCLIC(1)) dut_neg (
    .clk(clk), .reset(reset), .load(load), .en(en), .din(din),
    .head(head_n), .dout(dout_n), .rot_cnt(rot_n),
    .wrap(wrap_n), .phase(phase_n), .valid(valid_n)
  );

  poly_csr_bank #(.N(N), .W(W), .Q(Q), .NEGACYCLIC(0)) dut_cyc (
    .clk(clk), .reset(reset), .load(load), .en(en), .din(din),
    .head(head_c), .dout(dout_c), .rot_cnt(rot_c),
    .wrap(wrap_c), .phase(phase_c), .valid(valid_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the loaded polynomial plus a total rotation count k in [0, 2N).
  // Position i holds loaded[(i+k) mod N], negated when i+k falls in [N, 2N).
  int   m_loaded [N];
  int   m_k     = 0;
  logic m_valid = 1'b0;
  logic m_wrap  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      m_k     = 0;
      for (int i = 0; i < N; i++) m_loaded[i] = 0;
    end else begin
      m_wrap = 1'b0;
      if (load) begin
        for (int i = 0; i < N; i++) m_loaded[i] = int'(din[i*W +: W]);
        m_k     = 0;
        m_valid = 1'b1;
      end else if (en && m_valid) begin
        if ((m_k % N) == N - 1) m_wrap = 1'b1;
        m_k = (m_k + 1) % (2 * N);
      end
    end
  end

  function automatic logic [N*W-1:0] exp_dout(input bit negm);
    logic [N*W-1:0] r;
    int p, c;
    r = '0;
    for (int i = 0; i < N; i++) begin
      p = i + m_k;
      c = m_loaded[p % N];
      if (negm && ((p % (2 * N)) >= N) && (c != 0)) c = Q - c;
      r[i*W +: W] = c[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] pack(input int base);
    logic [N*W-1:0] r;
    int v;
    for (int i = 0; i < N; i++) begin
      v = base + i;
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N*W-1:0] en_d, ec_d;
      en_d = exp_dout(1'b1);
      ec_d = exp_dout(1'b0);
      check("neg_dout",  64'(dout_n),  64'(en_d));
      check("neg_head",  64'(head_n),  64'(en_d[W-1:0]));
      check("neg_rot",   64'(rot_n),   64'(m_k % N));
      check("neg_wrap",  64'(wrap_n),  64'(m_wrap));
      check("neg_phase", 64'(phase_n), 64'(m_k >= N));
      check("neg_valid", 64'(valid_n), 64'(m_valid));
      check("cyc_dout",  64'(dout_c),  64'(ec_d));
      check("cyc_rot",   64'(rot_c),   64'(m_k % N));
      check("cyc_wrap",  64'(wrap_c),  64'(m_wrap));
      check("cyc_phase", 64'(phase_c), 64'd0);
      check("cyc_valid", 64'(valid_c), 64'(m_valid));
    end
  end

  initial begin : stim
    int wraps;

    // Reset, then idle, then en before any load.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_valid", 64'(valid_n), 64'd0);
    check("idle_dout",  64'(dout_n),  64'd0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    check("noload_valid", 64'(valid_c), 64'd0);
    check("noload_rot",   64'(rot_c),   64'd0);
    check("noload_dout",  64'(dout_c),  64'd0);

    // Cyclic rotation of {7,...,0}.
    din = pack(0); load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("cyc_head0", 64'(head_c), 64'd0);
    en = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      check("cyc_head_step", 64'(head_c), 64'(r));
    end
    check("cyc_rot3", 64'(rot_c), 64'd3);
    repeat (5) @(negedge clk);
    check("cyc_wrap8",    64'(wrap_c),  64'd1);
    check("cyc_restored", 64'(dout_c),  64'(pack(0)));
    check("cyc_phase8",   64'(phase_c), 64'd0);
    en = 1'b0;
    @(negedge clk);
    check("cyc_wrap_once", 64'(wrap_c), 64'd0);

    // Negation at the wrap point, including zero.
    din = '0; din[W-1:0] = 8'd5; load = 1'b1;
    @(negedge clk); load = 1'b0; en = 1'b1;
    @(negedge clk); en = 1'b0;
    check("neg5_tail", 64'(dout_n[(N-1)*W +: W]), 64'd251);
    check("neg5_head", 64'(head_n), 64'd0);
    din = '0; load = 1'b1;
    @(negedge clk); load = 1'b0; en = 1'b1;
    @(negedge clk); en = 1'b0;
    check("neg0_tail", 64'(dout_n[(N-1)*W +: W]), 64'd0);

    // Full negacyclic cycle of {1..8}: 2N rotations, two wraps.
    din = pack(1); load = 1'b1;
    @(negedge clk); load = 1'b0; en = 1'b1;
    wraps = 0;
    for (int r = 1; r <= 2 * N; r++) begin
      @(negedge clk);
      wraps += int'(wrap_n);
      if (r == N) begin
        for (int i = 0; i < N; i++)
          check("full_negated", 64'(dout_n[i*W +: W]), 64'(256 - (i + 1)));
        check("full_phase1", 64'(phase_n), 64'd1);
        check("full_wrap1",  64'(wrap_n),  64'd1);
      end
      if (r == 2 * N) begin
        check("full_restored", 64'(dout_n),  64'(pack(1)));
        check("full_phase0",   64'(phase_n), 64'd0);
        check("full_wrap2",    64'(wrap_n),  64'd1);
      end
    end
    en = 1'b0;
    check("full_wrap_count", 64'(wraps), 64'd2);

    // load beats a simultaneous en mid-rotation.
    din = pack(1); load = 1'b1;
    @(negedge clk); load = 1'b0; en = 1'b1;
    repeat (5) @(negedge clk);
    din = pack(9); load = 1'b1;
    @(negedge clk); load = 1'b0; en = 1'b0;
    check("prio_dout",  64'(dout_n),  64'(pack(9)));
    check("prio_rot",   64'(rot_n),   64'd0);
    check("prio_wrap",  64'(wrap_n),  64'd0);
    check("prio_phase", 64'(phase_n), 64'd0);
    check("prio_cdout", 64'(dout_c),  64'(pack(9)));

    // Asynchronous reset between edges while rotating.
    din = pack(1); load = 1'b1;
    @(negedge clk); load = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_dout",  64'(dout_n),  64'd0);
    check("areset_valid", 64'(valid_n), 64'd0);
    check("areset_rot",   64'(rot_n),   64'd0);
    check("areset_cdout", 64'(dout_c),  64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_valid", 64'(valid_n), 64'd0);
    check("post_dout",  64'(dout_n),  64'd0);
    check("post_rot",   64'(rot_n),   64'd0);
    en = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_csr_bank.md
Name: poly_csr_bank

Overview:
- Responder side of the multiplier control interface: a circular shift register (CSR) bank holding one polynomial's N coefficients.
- Obeys the load/en strobes issued by the multiplier control unit (CSR1_load/CSR1_en or CSR2_load/CSR2_en map onto load/en).
- Presents the current head coefficient to the MAC datapath.
- Supports negacyclic rotation (ring Z_Q[x]/(x^N+1)), so the same bank serves cyclic and negacyclic multipliers.

Parameters:
- N, 8, number of coefficients (power of 2, >=2)
- W, 8, coefficient width in bits
- Q, 256, coefficient modulus for negation (2 <= Q <= 2^W)
- NEGACYCLIC, 1, 1 = wrapped coefficient is negated mod Q; 0 = plain cyclic rotation

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- load  input  1  parallel load strobe from control unit
- en  input  1  rotate-by-one strobe from control unit
- din  input  N*W  coefficients to load; coeff i at bits [i*W +: W]; each must be < Q
- head  output  W  current coefficient at position 0 (= dout[W-1:0])
- dout  output  N*W  full register contents, same packing as din
- rot_cnt  output  log2(N)  rotations since last load, mod N
- wrap  output  1  one-cycle pulse: registered in the cycle after the rotation that returns rot_cnt from N-1 to 0
- phase  output  1  toggles on each wrap; 1 = contents currently negated relative to loaded polynomial (always 0 when NEGACYCLIC=0)
- valid  output  1  bank holds loaded data

Behaviour:
- Reset (reset=0, async): all coefficient regs = 0; rot_cnt = 0; wrap = 0; phase = 0; valid = 0. Removal of reset is synchronous to clk and is handled by the integrating reset synchroniser.
- All updates happen on the rising clk edge. Outputs are registers, with no combinational path from inputs. Latency is 1 cycle from strobe to updated outputs.
- Priority: load > en.
- load=1:
  - reg[i] <= din[i] for all i.
  - rot_cnt <= 0, phase <= 0, wrap <= 0, valid <= 1.
  - Any simultaneous en is ignored.
- en=1, load=0, valid=1 (rotate toward index 0):
  - reg[i] <= reg[i+1] for i = 0..N-2.
  - reg[N-1] <= NEGACYCLIC ? neg(reg[0]) : reg[0].
  - neg(c) = (c==0) ? 0 : Q-c, computed in W+1 bits and truncated to W bits.
  - rot_cnt <= rot_cnt+1 mod N.
  - If rot_cnt was N-1: wrap <= 1 and phase <= ~phase (phase is forced to 0 when NEGACYCLIC=0). Otherwise wrap <= 0.
- en=1 with valid=0: ignored. Registers hold; wrap <= 0.
- No strobe: all registers hold; wrap <= 0.
- After N rotations in negacyclic mode, every coefficient has been negated once. After 2N rotations the contents equal the loaded values and phase = 0.
- Back-to-back en every cycle is legal; there is no bubble requirement.
- load may be reasserted at any time (mid-rotation): the new data fully replaces the old and the counters restart.
- Reset asserted mid-operation clears everything immediately (async), including valid.
- din coefficients >= Q are a protocol violation. The result is unspecified but must not hang the block; the bench must not drive such values.

Decomposition:
- Shared package poly_pkg:
  - default N, W, Q constants
  - CNT_W = $clog2(N)
  - function neg_mod(c, Q), reused by the future negacyclic MAC
- Optional sub-module poly_coef_neg: combinational W-bit mod-Q negation, instantiated once at the wrap point.
- The rest is a single flat module (shift array plus counter/flag logic).

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, hold 4 cycles -> dout=0, rot_cnt=0, wrap=0, phase=0, valid=0; en pulses before any load leave all outputs unchanged.
- Load + cyclic (NEGACYCLIC=0, N=8): load din={7,6,5,4,3,2,1,0}, then en for 3 cycles -> head = 0,1,2,3 on successive cycles; rot_cnt=3. After 8 total en: wrap=1 for exactly one cycle, contents = original, phase=0.
- Negacyclic wrap (Q=256): load coeff0=5, others 0, one en -> reg[7]=251, head=0. Load coeff0=0, one en -> reg[7]=0 (zero is not negated).
- Full negacyclic cycle: load {1..8}, 8 en -> every coeff = 256-orig, phase=1, one wrap pulse. 8 more en -> original values, phase=0, second wrap pulse.
- Priority/restart: after 5 en, assert load and en in the same cycle with din={9..16} -> dout=din, rot_cnt=0, wrap=0, phase=0.
- Async reset mid-rotation: with en held high, drop reset between clock edges -> outputs go to 0 and valid=0 before the next edge; after release, en is ignored until a load.
